ex_mem_stage_buf: RTL and testbench
===================================

// Module: ex_mem_stage_buf
// PURPOSE
//  Parametrised EX->MEM pipeline buffer holding execute-stage results.
//  Replaces the flat EX output bundle with a DEPTH-entry valid/ready queue, so EX can run ahead while MEM stalls.
//  Adds a bubble filter, synchronous flush, and a trap fence that holds EX after a scall/eret/udf result.
//  Sits between the execute unit (upstream) and the memory/IO stage (downstream).
// PARAMETERS
//  XLEN          32  width of pc, nextpc, alu_res and op3
//  REG_W          5  destination register index width
//  CTRL_W        16  packed control: w_rd,w_cr,link,mem_r,mem_w,mem_sz[1:0],mem_sx,io_r,io_w,mfsr,mtsr,mfcr,scall,eret,udf
//  DEPTH          2  queue entries; any integer >= 1
//  DROP_BUBBLES   1  1: bubble inputs are consumed and not stored; 0: bubbles are stored as entries
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  flush        in   1         synchronous kill of all entries and of the fence
//  in_valid     in   1         upstream result valid
//  in_ready     out  1         buffer accepts this cycle
//  in_bubble    in   1         upstream slot is a bubble
//  in_trap      in   1         entry is scall/eret/udf (arms the fence)
//  in_pc        in   XLEN      instruction pc
//  in_nextpc    in   XLEN      next pc
//  in_alu_res   in   XLEN      ALU result
//  in_op3       in   XLEN      store data / third operand
//  in_cmp_res   in   2         compare result
//  in_rd        in   REG_W     destination register
//  in_ctrl      in   CTRL_W    packed control bits (order above)
//  out_valid    out  1         head entry valid
//  out_ready    in   1         downstream consumes head
//  out_bubble   out  1         ~out_valid, or stored bubble at head (DROP_BUBBLES=0)
//  out_trap, out_pc, out_nextpc, out_alu_res, out_op3, out_cmp_res, out_rd, out_ctrl  out  as in_*  head entry fields
//  out_count    out  $clog2(DEPTH+1)  current occupancy
//  fence        out  1         trap fence active
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, rd/wr ptr=0, fence=0, all storage zeroed.
//    Outputs after reset: out_valid=0, out_bubble=1, in_ready=1, out_count=0, all out_* fields = 0.
//  - in_ready = (count < DEPTH) & ~fence & ~flush. No full-queue pass-through: when count==DEPTH, in_ready=0 even if dequeuing.
//  - accept = in_valid & in_ready. Store when accept & ~(DROP_BUBBLES & in_bubble).
//    A dropped bubble is consumed and changes no state.
//  - Latency: an entry stored at edge N appears at the outputs after edge N. No combinational in->out path.
//  - out_valid = (count != 0) & ~flush. Head = mem[rd_ptr]. deq = out_valid & out_ready.
//  - Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
//  - Pointers wrap from DEPTH-1 to 0 by explicit compare, so DEPTH need not be a power of 2.
//  - Held handshake: while in_valid & ~in_ready, upstream holds its data and nothing is lost.
//    out_* fields stay stable while out_valid & ~out_ready.
//  - Fence: set on the edge that stores an entry with in_trap=1.
//    Fence clears on the edge that dequeues the trap entry, or on flush.
//    While fence=1, in_ready=0.
//  - Flush (sync, highest priority): during the flush cycle, in_ready=0 and out_valid=0.
//    Next edge: count=0, ptrs=0, fence=0, and any same-cycle enqueue/dequeue is suppressed.
//    Storage contents are not cleared.
//  - Async reset mid-transfer discards every entry immediately.
// TESTING
//  1. Reset, then push pc=0x100 and 0x104 with out_ready=0 -> count=2, in_ready=0, out_pc=0x100 held stable.
//  2. Full queue, out_ready=1 and in_valid=1 in the same cycle -> only the dequeue happens (count 2->1); pc=0x108 is accepted the next cycle.
//  3. DROP_BUBBLES=1, in_valid=1, in_bubble=1 -> in_ready=1, count stays 0, out_bubble=1.
//  4. Push an entry with in_trap=1, then one with pc=0x20 -> fence=1 and in_ready=0.
//     After the trap entry dequeues, fence=0 and 0x20 is accepted.
//  5. Two entries queued, flush=1 with in_valid=1 and out_ready=1 -> out_valid=0 that cycle; next cycle count=0 and nothing is dequeued or stored.
//  6. DEPTH=3, stream 10 entries with random out_ready -> in-order delivery across pointer wrap; out_count never exceeds 3.

Source files
------------

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline buffer: a DEPTH-entry valid/ready queue of execute results.
// It drops bubbles, supports a synchronous flush, and fences EX behind trap results.
module ex_mem_stage_buf #(
    parameter int XLEN         = 32,
    parameter int REG_W        = 5,
    parameter int CTRL_W       = 16,
    parameter int DEPTH        = 2,
    parameter int DROP_BUBBLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_bubble,
    input  logic                         in_trap,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [XLEN-1:0]              in_nextpc,
    input  logic [XLEN-1:0]              in_alu_res,
    input  logic [XLEN-1:0]              in_op3,
    input  logic [1:0]                   in_cmp_res,
    input  logic [REG_W-1:0]             in_rd,
    input  logic [CTRL_W-1:0]            in_ctrl,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_bubble,
    output logic                         out_trap,
    output logic [XLEN-1:0]              out_pc,
    output logic [XLEN-1:0]              out_nextpc,
    output logic [XLEN-1:0]              out_alu_res,
    output logic [XLEN-1:0]              out_op3,
    output logic [1:0]                   out_cmp_res,
    output logic [REG_W-1:0]             out_rd,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   out_count,
    output logic                         fence
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   mem_pc     [DEPTH];
    logic [XLEN-1:0]   mem_nextpc [DEPTH];
    logic [XLEN-1:0]   mem_alu    [DEPTH];
    logic [XLEN-1:0]   mem_op3    [DEPTH];
    logic [1:0]        mem_cmp    [DEPTH];
    logic [REG_W-1:0]  mem_rd     [DEPTH];
    logic [CTRL_W-1:0] mem_ctrl   [DEPTH];
    logic              mem_bubble [DEPTH];
    logic              mem_trap   [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              fence_q;
    logic              accept;
    logic              store;
    logic              deq;

    // Full queue never accepts, even when the head leaves this cycle.
    assign in_ready  = (count < CNT_W'(DEPTH)) & ~fence_q & ~flush;
    assign accept    = in_valid & in_ready;
    assign store     = accept & ~((DROP_BUBBLES != 0) & in_bubble);
    assign out_valid = (count != '0) & ~flush;
    assign deq       = out_valid & out_ready;

    assign out_pc      = mem_pc[rd_ptr];
    assign out_nextpc  = mem_nextpc[rd_ptr];
    assign out_alu_res = mem_alu[rd_ptr];
    assign out_op3     = mem_op3[rd_ptr];
    assign out_cmp_res = mem_cmp[rd_ptr];
    assign out_rd      = mem_rd[rd_ptr];
    assign out_ctrl    = mem_ctrl[rd_ptr];
    assign out_trap    = mem_trap[rd_ptr];
    assign out_bubble  = ~out_valid | ((DROP_BUBBLES == 0) & mem_bubble[rd_ptr]);
    assign out_count   = count;
    assign fence       = fence_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            fence_q <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            fence_q <= 1'b0;
        end else begin
            if (store) wr_ptr <= ptr_inc(wr_ptr);
            if (deq)   rd_ptr <= ptr_inc(rd_ptr);
            case ({store, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A trap entry is always the youngest, so its departure empties the fence.
            if (store && in_trap)
                fence_q <= 1'b1;
            else if (deq && out_trap)
                fence_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]     <= '0;
                mem_nextpc[i] <= '0;
                mem_alu[i]    <= '0;
                mem_op3[i]    <= '0;
                mem_cmp[i]    <= '0;
                mem_rd[i]     <= '0;
                mem_ctrl[i]   <= '0;
                mem_bubble[i] <= 1'b0;
                mem_trap[i]   <= 1'b0;
            end
        end else if (store) begin
            mem_pc[wr_ptr]     <= in_pc;
            mem_nextpc[wr_ptr] <= in_nextpc;
            mem_alu[wr_ptr]    <= in_alu_res;
            mem_op3[wr_ptr]    <= in_op3;
            mem_cmp[wr_ptr]    <= in_cmp_res;
            mem_rd[wr_ptr]     <= in_rd;
            mem_ctrl[wr_ptr]   <= in_ctrl;
            mem_bubble[wr_ptr] <= in_bubble;
            mem_trap[wr_ptr]   <= in_trap;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Bench for ex_mem_stage_buf: a vector table on a DEPTH=2 instance, a scoreboarded
// random-backpressure stream on a DEPTH=3 instance, and an async reset corner.
module tb_ex_mem_stage_buf;

    localparam logic [31:0] ALU_K = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic        flush, in_valid, in_ready, in_bubble, in_trap;
    logic [31:0] in_pc, in_nextpc, in_alu_res, in_op3;
    logic [1:0]  in_cmp_res;
    logic [4:0]  in_rd;
    logic [15:0] in_ctrl;
    logic        out_valid, out_ready, out_bubble, out_trap, fence;
    logic [31:0] out_pc, out_nextpc, out_alu_res, out_op3;
    logic [1:0]  out_cmp_res;
    logic [4:0]  out_rd;
    logic [15:0] out_ctrl;
    logic [1:0]  out_count;

    // DEPTH=3 instance
    logic        d3_flush, d3_in_valid, d3_in_ready, d3_in_bubble, d3_in_trap;
    logic [31:0] d3_in_pc, d3_in_nextpc, d3_in_alu_res, d3_in_op3;
    logic [1:0]  d3_in_cmp_res;
    logic [4:0]  d3_in_rd;
    logic [15:0] d3_in_ctrl;
    logic        d3_out_valid, d3_out_ready, d3_out_bubble, d3_out_trap, d3_fence;
    logic [31:0] d3_out_pc, d3_out_nextpc, d3_out_alu_res, d3_out_op3;
    logic [1:0]  d3_out_cmp_res;
    logic [4:0]  d3_out_rd;
    logic [15:0] d3_out_ctrl;
    logic [1:0]  d3_out_count;

    ex_mem_stage_buf #(.XLEN(32), .REG_W(5), .CTRL_W(16), .DEPTH(2), .DROP_BUBBLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble), .in_trap(in_trap),
        .in_pc(in_pc), .in_nextpc(in_nextpc), .in_alu_res(in_alu_res), .in_op3(in_op3),
        .in_cmp_res(in_cmp_res), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_bubble(out_bubble), .out_trap(out_trap),
        .out_pc(out_pc), .out_nextpc(out_nextpc), .out_alu_res(out_alu_res), .out_op3(out_op3),
        .out_cmp_res(out_cmp_res), .out_rd(out_rd), .out_ctrl(out_ctrl),
        .out_count(out_count), .fence(fence)
    );

    ex_mem_stage_buf #(.XLEN(32), .REG_W(5), .CTRL_W(16), .DEPTH(3), .DROP_BUBBLES(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(d3_flush),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_bubble(d3_in_bubble), .in_trap(d3_in_trap),
        .in_pc(d3_in_pc), .in_nextpc(d3_in_nextpc), .in_alu_res(d3_in_alu_res), .in_op3(d3_in_op3),
        .in_cmp_res(d3_in_cmp_res), .in_rd(d3_in_rd), .in_ctrl(d3_in_ctrl),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_bubble(d3_out_bubble), .out_trap(d3_out_trap),
        .out_pc(d3_out_pc), .out_nextpc(d3_out_nextpc), .out_alu_res(d3_out_alu_res), .out_op3(d3_out_op3),
        .out_cmp_res(d3_out_cmp_res), .out_rd(d3_out_rd), .out_ctrl(d3_out_ctrl),
        .out_count(d3_out_count), .fence(d3_fence)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv, bub, trap, ordy, fl;
        logic [31:0] pc;
        logic        e_ir, e_ov, e_bub;
        logic [1:0]  e_cnt;
        logic        e_fence, chk_pc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, bub, trap, ordy, fl, input logic [31:0] pc,
                                input logic e_ir, e_ov, e_bub, input logic [1:0] e_cnt,
                                input logic e_fence, chk_pc, input logic [31:0] e_pc);
        vec_t v;
        v.iv = iv; v.bub = bub; v.trap = trap; v.ordy = ordy; v.fl = fl; v.pc = pc;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_bub = e_bub; v.e_cnt = e_cnt;
        v.e_fence = e_fence; v.chk_pc = chk_pc; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic drive_d1(input logic iv, bub, trap, ordy, fl, input logic [31:0] pc);
        in_valid   = iv;
        in_bubble  = bub;
        in_trap    = trap;
        out_ready  = ordy;
        flush      = fl;
        in_pc      = pc;
        in_nextpc  = pc + 32'd4;
        in_alu_res = pc ^ ALU_K;
        in_op3     = ~pc;
        in_cmp_res = pc[3:2];
        in_rd      = pc[6:2];
        in_ctrl    = pc[15:0] ^ 16'h3C00;
    endtask

    initial begin
        logic [31:0] sb[$];
        logic [31:0] exp_pc;
        int sent, rcvd, mcnt;
        logic acc, dq;

        drive_d1(0, 0, 0, 0, 0, 32'h0);
        d3_flush = 0; d3_in_valid = 0; d3_in_bubble = 0; d3_in_trap = 0; d3_out_ready = 0;
        d3_in_pc = 0; d3_in_nextpc = 0; d3_in_alu_res = 0; d3_in_op3 = 0;
        d3_in_cmp_res = 0; d3_in_rd = 0; d3_in_ctrl = 0;

        // iv bub trap ordy fl pc      | ir ov bub cnt fence chk_pc e_pc
        vecs.push_back(mk(1,0,0,0,0,32'h100, 1,0,1,2'd0,0,0,32'h0));
        vecs.push_back(mk(1,0,0,0,0,32'h104, 1,1,0,2'd1,0,1,32'h100));
        vecs.push_back(mk(1,0,0,0,0,32'h108, 0,1,0,2'd2,0,1,32'h100));
        vecs.push_back(mk(1,0,0,1,0,32'h108, 0,1,0,2'd2,0,1,32'h100));
        vecs.push_back(mk(1,0,0,0,0,32'h108, 1,1,0,2'd1,0,1,32'h104));
        vecs.push_back(mk(0,0,0,1,0,32'h0,   0,1,0,2'd2,0,1,32'h104));
        vecs.push_back(mk(0,0,0,1,0,32'h0,   1,1,0,2'd1,0,1,32'h108));
        vecs.push_back(mk(1,1,0,0,0,32'h200, 1,0,1,2'd0,0,0,32'h0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,   1,0,1,2'd0,0,0,32'h0));
        vecs.push_back(mk(1,0,1,0,0,32'h300, 1,0,1,2'd0,0,0,32'h0));
        vecs.push_back(mk(1,0,0,0,0,32'h20,  0,1,0,2'd1,1,1,32'h300));
        vecs.push_back(mk(1,0,0,1,0,32'h20,  0,1,0,2'd1,1,1,32'h300));
        vecs.push_back(mk(1,0,0,0,0,32'h20,  1,0,1,2'd0,0,0,32'h0));
        vecs.push_back(mk(1,0,0,0,0,32'h24,  1,1,0,2'd1,0,1,32'h20));
        vecs.push_back(mk(1,0,0,1,1,32'h28,  0,0,1,2'd2,0,0,32'h0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,   1,0,1,2'd0,0,0,32'h0));
        vecs.push_back(mk(1,0,0,0,0,32'h40,  1,0,1,2'd0,0,0,32'h0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,   1,1,0,2'd1,0,1,32'h40));
        vecs.push_back(mk(0,0,0,1,0,32'h0,   1,1,0,2'd1,0,1,32'h40));
        vecs.push_back(mk(0,0,0,0,0,32'h0,   1,0,1,2'd0,0,0,32'h0));
        vecs.push_back(mk(1,0,1,0,0,32'h50,  1,0,1,2'd0,0,0,32'h0));
        vecs.push_back(mk(0,0,0,0,1,32'h0,   0,0,1,2'd1,1,0,32'h0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,   1,0,1,2'd0,0,0,32'h0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst out_bubble", {31'd0, out_bubble}, 32'd1);
        chk("rst in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst out_count",  {30'd0, out_count},  32'd0);
        chk("rst fence",      {31'd0, fence},      32'd0);
        chk("rst out_pc",     out_pc,              32'd0);
        chk("rst out_alu",    out_alu_res,         32'd0);
        chk("rst out_misc",   {out_nextpc ^ out_op3, out_cmp_res != 2'd0, out_rd != 5'd0,
                               out_ctrl != 16'd0, out_trap} != '0 ? 32'd1 : 32'd0, 32'd0);
        chk("rst d3 in_ready", {31'd0, d3_in_ready}, 32'd1);

        foreach (vecs[i]) begin
            drive_d1(vecs[i].iv, vecs[i].bub, vecs[i].trap, vecs[i].ordy, vecs[i].fl, vecs[i].pc);
            #1;
            chk($sformatf("v%0d in_ready", i),   {31'd0, in_ready},   {31'd0, vecs[i].e_ir});
            chk($sformatf("v%0d out_valid", i),  {31'd0, out_valid},  {31'd0, vecs[i].e_ov});
            chk($sformatf("v%0d out_bubble", i), {31'd0, out_bubble}, {31'd0, vecs[i].e_bub});
            chk($sformatf("v%0d out_count", i),  {30'd0, out_count},  {30'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d fence", i),      {31'd0, fence},      {31'd0, vecs[i].e_fence});
            if (vecs[i].chk_pc) begin
                chk($sformatf("v%0d out_pc", i),  out_pc,      vecs[i].e_pc);
                chk($sformatf("v%0d out_alu", i), out_alu_res, vecs[i].e_pc ^ ALU_K);
                chk($sformatf("v%0d out_nextpc", i), out_nextpc, vecs[i].e_pc + 32'd4);
            end
            @(posedge clk); #1;
        end
        drive_d1(0, 0, 0, 0, 0, 32'h0);

        // DEPTH=3 stream with random backpressure across pointer wrap
        sent = 0; rcvd = 0; mcnt = 0;
        for (int cyc = 0; cyc < 400 && rcvd < 10; cyc++) begin
            d3_in_valid   = (sent < 10);
            d3_in_pc      = 32'h1000 + 32'(sent) * 32'd4;
            d3_in_nextpc  = d3_in_pc + 32'd4;
            d3_in_alu_res = d3_in_pc ^ ALU_K;
            d3_in_op3     = ~d3_in_pc;
            d3_in_rd      = d3_in_pc[6:2];
            d3_in_ctrl    = d3_in_pc[15:0];
            d3_out_ready  = 1'($urandom_range(0, 1));
            #1;
            chk("d3 in_ready",  {31'd0, d3_in_ready},  (mcnt < 3) ? 32'd1 : 32'd0);
            chk("d3 out_valid", {31'd0, d3_out_valid}, (mcnt != 0) ? 32'd1 : 32'd0);
            chk("d3 out_count", {30'd0, d3_out_count}, 32'(mcnt));
            chk("d3 count_le3", (d3_out_count <= 2'd3) ? 32'd1 : 32'd0, 32'd1);
            dq  = (mcnt != 0) && d3_out_ready;
            acc = d3_in_valid && (mcnt < 3);
            if (dq) begin
                exp_pc = sb.pop_front();
                chk($sformatf("d3 out_pc #%0d", rcvd), d3_out_pc, exp_pc);
                chk($sformatf("d3 out_alu #%0d", rcvd), d3_out_alu_res, exp_pc ^ ALU_K);
                rcvd++;
            end
            if (acc) begin
                sb.push_back(d3_in_pc);
                sent++;
            end
            mcnt = mcnt + (acc ? 1 : 0) - (dq ? 1 : 0);
            @(posedge clk); #1;
        end
        d3_in_valid = 0;
        d3_out_ready = 0;
        chk("d3 stream delivered", 32'(rcvd), 32'd10);

        // Async reset while an entry is held
        drive_d1(1, 0, 0, 0, 0, 32'h60);
        @(posedge clk); #1;
        drive_d1(0, 0, 0, 0, 0, 32'h0);
        chk("pre-rst out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst out_count", {30'd0, out_count}, 32'd0);
        chk("async rst out_pc",    out_pc,             32'd0);
        chk("async rst in_ready",  {31'd0, in_ready},  32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst out_valid", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
